rede_float_out_collector: RTL and testbench

Per-port output buffer sitting directly downstream of the `rede_float` processor wrapper. Captures the 28-bit `io_out` word whenever one of the `out_en` port strobes fires. Holds each port's words in its own small FIFO. Drains all ports onto a single valid/ready stream, tagged with the port index, using round-robin arbitration. Lets a slow or stalling consumer coexist with the processor's single-cycle output strobes; lost words are reported through per-port sticky overflow flags.

---
 rtl/rede_float_out_collector.sv | 137 +++++++++++++
 tb/tb_rede_float_out_collector.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rede_float_out_collector.sv
// rtl/rede_float_out_collector.sv - per-port output FIFOs drained round-robin onto one port-tagged stream
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   io_out   in   NBITS data word from the processor
//   out_en   in   NPORT per-port write strobes
//   m_data   out  NBITS head word of the granted port (0 when idle)
//   m_port   out  PBITS index of the granted port (0 when idle)
//   m_valid  out  a word is offered on m_data/m_port
//   m_ready  in   consumer accepts the offered word
//   ovf      out  NPORT sticky overflow flags
//   ovf_clr  in   clears all overflow flags
module rede_float_out_collector #(
  parameter int NBITS = 28,
  parameter int NPORT = 4,
  parameter int PBITS = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] io_out,
  input  logic [NPORT-1:0] out_en,
  output logic [NBITS-1:0] m_data,
  output logic [PBITS-1:0] m_port,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [NPORT-1:0] ovf,
  input  logic             ovf_clr
);

  localparam int ABITS = $clog2(DEPTH);
  localparam int CBITS = ABITS + 1;

  logic [NBITS-1:0] mem_q  [NPORT][DEPTH];
  logic [ABITS-1:0] wptr_q [NPORT];
  logic [ABITS-1:0] rptr_q [NPORT];
  logic [CBITS-1:0] cnt_q  [NPORT];
  logic [CBITS-1:0] cnt_d  [NPORT];
  logic [PBITS-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [PBITS-1:0] lock_port_q, lock_port_d;
  logic [NPORT-1:0] ovf_q, ovf_d;

  logic             found;
  logic [PBITS-1:0] srch;
  logic [PBITS-1:0] gnt;
  logic             pop;
  logic [NPORT-1:0] pop_k;
  logic [NPORT-1:0] wr_k;
  logic [NPORT-1:0] ovf_set;

  // Round-robin search starting at rr_q. Depends only on registered state,
  // so no input reaches the outputs combinationally.
  always_comb begin
    found = 1'b0;
    srch  = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (!found && cnt_q[PBITS'((int'(rr_q) + i) % NPORT)] != '0) begin
        found = 1'b1;
        srch  = PBITS'((int'(rr_q) + i) % NPORT);
      end
    end
  end

  // A locked grant keeps the offered word stable across a stall; the locked
  // FIFO cannot drain without a handshake, so it is still non-empty.
  always_comb begin
    gnt     = lock_q ? lock_port_q : srch;
    m_valid = lock_q | found;
    m_port  = m_valid ? gnt : '0;
    m_data  = m_valid ? mem_q[gnt][rptr_q[gnt]] : '0;
    ovf     = ovf_q;
  end

  always_comb begin
    pop         = m_valid & m_ready;
    lock_d      = m_valid & ~m_ready;
    lock_port_d = gnt;
    rr_d        = rr_q;
    if (pop) begin
      rr_d = (gnt == PBITS'(NPORT - 1)) ? '0 : gnt + 1'b1;
    end
    for (int k = 0; k < NPORT; k++) begin
      pop_k[k] = pop && (gnt == PBITS'(k));
      // A full FIFO popped this cycle frees its head slot, so the write lands.
      wr_k[k]    = out_en[k] && ((cnt_q[k] != CBITS'(DEPTH)) || pop_k[k]);
      ovf_set[k] = out_en[k] && (cnt_q[k] == CBITS'(DEPTH)) && !pop_k[k];
      cnt_d[k]   = cnt_q[k];
      if (wr_k[k] && !pop_k[k]) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (!wr_k[k] && pop_k[k]) begin
        cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
    // Set has priority over clear.
    ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      ovf_q       <= '0;
      for (int k = 0; k < NPORT; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      ovf_q       <= ovf_d;
      for (int k = 0; k < NPORT; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (wr_k[k]) begin
          wptr_q[k] <= wptr_q[k] + 1'b1;
        end
        if (pop_k[k]) begin
          rptr_q[k] <= rptr_q[k] + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset; counts define which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NPORT; k++) begin
      if (rst && wr_k[k]) begin
        mem_q[k][wptr_q[k]] <= io_out;
      end
    end
  end

endmodule

// File: tb/tb_rede_float_out_collector.sv
// tb/tb_rede_float_out_collector.sv - directed self-checking bench for rede_float_out_collector
module tb_rede_float_out_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] io_out;
  logic [3:0]  out_en;
  logic [27:0] m_data;
  logic [1:0]  m_port;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  ovf;
  logic        ovf_clr;

  int tests  = 0;
  int failed = 0;

  rede_float_out_collector dut (
    .clk     (clk),
    .rst     (rst),
    .io_out  (io_out),
    .out_en  (out_en),
    .m_data  (m_data),
    .m_port  (m_port),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [1:0] port, input logic [27:0] data);
    chk({tag, " valid"}, 32'(m_valid), 32'd1);
    chk({tag, " port"}, 32'(m_port), 32'(port));
    chk({tag, " data"}, 32'(m_data), 32'(data));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wr(input logic [3:0] en, input logic [27:0] v);
    out_en = en;
    io_out = v;
    tick();
    out_en = 4'b0000;
  endtask

  initial begin
    rst     = 1'b0;
    io_out  = 28'h1234567;
    out_en  = 4'b1111;
    m_ready = 1'b0;
    ovf_clr = 1'b0;

    // Reset held three cycles with all strobes active
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst valid", 32'(m_valid), 32'd0);
      chk("rst data", 32'(m_data), 32'd0);
      chk("rst port", 32'(m_port), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
    end
    rst    = 1'b1;
    out_en = 4'b0000;
    tick();
    chk("post-rst empty", 32'(m_valid), 32'd0);

    // Single capture
    m_ready = 1'b1;
    wr(4'b0100, 28'h0ABCDEF);
    chk_word("single", 2'd2, 28'h0ABCDEF);
    tick();
    chk("single drained", 32'(m_valid), 32'd0);

    // Round robin
    do_reset();
    m_ready = 1'b0;
    wr(4'b0001, 28'd10);
    wr(4'b0001, 28'd11);
    wr(4'b0010, 28'd20);
    wr(4'b0010, 28'd21);
    wr(4'b1000, 28'd30);
    wr(4'b1000, 28'd31);
    m_ready = 1'b1;
    chk_word("rr0", 2'd0, 28'd10); tick();
    chk_word("rr1", 2'd1, 28'd20); tick();
    chk_word("rr2", 2'd3, 28'd30); tick();
    chk_word("rr3", 2'd0, 28'd11); tick();
    chk_word("rr4", 2'd1, 28'd21); tick();
    chk_word("rr5", 2'd3, 28'd31); tick();
    chk("rr empty", 32'(m_valid), 32'd0);

    // Stall stability: port 3 locked while port 0 (next in rr order) fills
    m_ready = 1'b0;
    wr(4'b1000, 28'd7);
    chk_word("stall a", 2'd3, 28'd7);
    wr(4'b0001, 28'd5);
    chk_word("stall b", 2'd3, 28'd7);
    tick();
    chk_word("stall c", 2'd3, 28'd7);
    m_ready = 1'b1;
    chk_word("stall d", 2'd3, 28'd7); tick();
    chk_word("stall e", 2'd0, 28'd5); tick();
    chk("stall empty", 32'(m_valid), 32'd0);

    // Overflow: nine writes into an eight-deep FIFO
    m_ready = 1'b0;
    for (int v = 1; v <= 9; v++) wr(4'b0010, 28'(v));
    chk("ovf set", 32'(ovf), 32'h2);
    m_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      chk_word("ovf drain", 2'd1, 28'(v));
      tick();
    end
    chk("ovf drained", 32'(m_valid), 32'd0);
    chk("ovf sticky", 32'(ovf), 32'h2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf cleared", 32'(ovf), 32'd0);

    // Full FIFO with simultaneous pop and write
    m_ready = 1'b0;
    for (int v = 0; v < 8; v++) wr(4'b0010, 28'h40 + 28'(v));
    chk("full no ovf", 32'(ovf), 32'd0);
    chk_word("full head", 2'd1, 28'h40);
    m_ready = 1'b1;
    wr(4'b0010, 28'h99);
    chk("popwr no ovf", 32'(ovf), 32'd0);
    m_ready = 1'b0;
    wr(4'b0010, 28'hAA);
    chk("still full ovf", 32'(ovf), 32'h2);
    m_ready = 1'b1;
    for (int v = 1; v < 8; v++) begin
      chk_word("popwr drain", 2'd1, 28'h40 + 28'(v));
      tick();
    end
    chk_word("popwr last", 2'd1, 28'h99);
    tick();
    chk("popwr empty", 32'(m_valid), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Broadcast of a negative word
    do_reset();
    m_ready = 1'b0;
    wr(4'b1001, 28'hFFFFFFD);
    chk_word("bcast a", 2'd0, 28'hFFFFFFD);
    m_ready = 1'b1;
    tick();
    chk_word("bcast b", 2'd3, 28'hFFFFFFD);
    tick();
    chk("bcast empty", 32'(m_valid), 32'd0);
    chk("bcast ovf", 32'(ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
